// File: rtl/regfile_mp.sv
// Multi-port integer register file with busy scoreboard for the xgriscv pipeline.
// Optional same-cycle write forwarding on the read ports when RF_BYPASS_EN is defined.
module regfile_mp #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned AW   = 5,
  parameter int unsigned NREG = 32,
  parameter int unsigned NRD  = 2
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic [NRD*AW-1:0]   ra,
  output logic [NRD*XLEN-1:0] rd,
  output logic [NRD-1:0]      rbusy,
  input  logic                we0,
  input  logic [AW-1:0]       wa0,
  input  logic [XLEN-1:0]     wd0,
  input  logic                we1,
  input  logic [AW-1:0]       wa1,
  input  logic [XLEN-1:0]     wd1,
  input  logic                iss_v,
  input  logic [AW-1:0]       iss_rd,
  input  logic                flush,
  output logic [AW:0]         nbusy
);

  localparam logic [AW:0] NREG_L = (AW+1)'(NREG);

  logic [XLEN-1:0] regs [NREG];
  logic [NREG-1:0] busy;
  logic [NREG-1:0] busy_d;
  logic [AW:0]     nbusy_d;
  logic            wv0;
  logic            wv1;
  logic            isv;

  // Qualified write/issue strobes: x0 and out-of-range indices are dropped here
  assign wv0 = we0 && (wa0 != '0) && ({1'b0, wa0} < NREG_L);
  assign wv1 = we1 && (wa1 != '0) && ({1'b0, wa1} < NREG_L);
  assign isv = iss_v && (iss_rd != '0) && ({1'b0, iss_rd} < NREG_L);

  // Register array; lane 1 overrides lane 0 on an address collision
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int unsigned r = 0; r < NREG; r++) regs[r] <= '0;
    end else begin
      for (int unsigned r = 1; r < NREG; r++) begin
        if (wv1 && (wa1 == AW'(r)))      regs[r] <= wd1;
        else if (wv0 && (wa0 == AW'(r))) regs[r] <= wd0;
      end
    end
  end

  // Scoreboard next state: flush, then writeback clears, then issue set
  always_comb begin
    busy_d  = busy;
    nbusy_d = '0;
    if (flush) begin
      busy_d = '0;
    end else begin
      for (int unsigned r = 1; r < NREG; r++) begin
        if (wv0 && (wa0 == AW'(r))) busy_d[r] = 1'b0;
        if (wv1 && (wa1 == AW'(r))) busy_d[r] = 1'b0;
        if (isv && (iss_rd == AW'(r))) busy_d[r] = 1'b1;
      end
    end
    busy_d[0] = 1'b0;
    for (int unsigned r = 0; r < NREG; r++) nbusy_d = nbusy_d + (AW+1)'(busy_d[r]);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      busy  <= '0;
      nbusy <= '0;
    end else begin
      busy  <= busy_d;
      nbusy <= nbusy_d;
    end
  end

  // Combinational read ports; unmatched (out-of-range) addresses read 0 / not busy
  for (genvar i = 0; i < int'(NRD); i++) begin : g_rd
    logic [AW-1:0]   addr;
    logic [XLEN-1:0] val;
    logic            bz;

    assign addr = ra[i*AW +: AW];

    always_comb begin
      val = '0;
      bz  = 1'b0;
      for (int unsigned r = 0; r < NREG; r++) begin
        if (addr == AW'(r)) begin
          val = regs[r];
          bz  = busy[r];
        end
      end
`ifdef RF_BYPASS_EN
      if (wv1 && (wa1 == addr))      val = wd1;
      else if (wv0 && (wa0 == addr)) val = wd0;
      if (((wv1 && (wa1 == addr)) || (wv0 && (wa0 == addr))) && !(isv && (iss_rd == addr)))
        bz = 1'b0;
`endif
    end

    assign rd[i*XLEN +: XLEN] = val;
    assign rbusy[i]           = bz;
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed self-checking bench for regfile_mp (default parameters).
module tb_regfile_mp;

  logic        clk;
  logic        rstn;
  logic [9:0]  ra;
  logic [63:0] rd;
  logic [1:0]  rbusy;
  logic        we0;
  logic [4:0]  wa0;
  logic [31:0] wd0;
  logic        we1;
  logic [4:0]  wa1;
  logic [31:0] wd1;
  logic        iss_v;
  logic [4:0]  iss_rd;
  logic        flush;
  logic [5:0]  nbusy;

  int checks = 0;
  int errors = 0;

  regfile_mp dut (
    .clk    (clk),
    .rstn   (rstn),
    .ra     (ra),
    .rd     (rd),
    .rbusy  (rbusy),
    .we0    (we0),
    .wa0    (wa0),
    .wd0    (wd0),
    .we1    (we1),
    .wa1    (wa1),
    .wd1    (wd1),
    .iss_v  (iss_v),
    .iss_rd (iss_rd),
    .flush  (flush),
    .nbusy  (nbusy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    we0 = 1'b0; wa0 = '0; wd0 = '0;
    we1 = 1'b0; wa1 = '0; wd1 = '0;
    iss_v = 1'b0; iss_rd = '0; flush = 1'b0;
  endtask

  task automatic test_reset();
    idle();
    rstn = 1'b0;
    ra = {5'd5, 5'd3};
    #12;
    checks++; if (rd !== 64'h0) begin errors++; $display("FAIL reset_rd got=%h exp=0", rd); end
    checks++; if (rbusy !== 2'b00) begin errors++; $display("FAIL reset_rbusy got=%b exp=00", rbusy); end
    checks++; if (nbusy !== 6'd0) begin errors++; $display("FAIL reset_nbusy got=%0d exp=0", nbusy); end
    rstn = 1'b1;
    tick();
    checks++; if (rd !== 64'h0) begin errors++; $display("FAIL post_reset_rd got=%h exp=0", rd); end
    checks++; if (nbusy !== 6'd0) begin errors++; $display("FAIL post_reset_nbusy got=%0d exp=0", nbusy); end
  endtask

  task automatic test_write_read();
    logic [31:0] exp_pre;
    ra = {5'd3, 5'd5};
    we0 = 1'b1; wa0 = 5'd5; wd0 = 32'hDEADBEEF;
`ifdef RF_BYPASS_EN
    exp_pre = 32'hDEADBEEF;
`else
    exp_pre = 32'h0;
`endif
    #2;
    checks++; if (rd[31:0] !== exp_pre) begin errors++; $display("FAIL wr_same_cycle got=%h exp=%h", rd[31:0], exp_pre); end
    tick();
    idle();
    #1;
    checks++; if (rd[31:0] !== 32'hDEADBEEF) begin errors++; $display("FAIL wr_next_cycle got=%h exp=deadbeef", rd[31:0]); end
  endtask

  task automatic test_conflict();
    we0 = 1'b1; wa0 = 5'd7; wd0 = 32'h1111_1111;
    we1 = 1'b1; wa1 = 5'd7; wd1 = 32'h2222_2222;
    tick();
    idle();
    ra = {5'd5, 5'd7};
    #1;
    checks++; if (rd[31:0] !== 32'h2222_2222) begin errors++; $display("FAIL conflict_x7 got=%h exp=22222222", rd[31:0]); end
    checks++; if (rd[63:32] !== 32'hDEADBEEF) begin errors++; $display("FAIL conflict_x5 got=%h exp=deadbeef", rd[63:32]); end
  endtask

  task automatic test_x0();
    we0 = 1'b1; wa0 = 5'd0; wd0 = 32'hFFFF_FFFF;
    we1 = 1'b1; wa1 = 5'd0; wd1 = 32'hFFFF_FFFF;
    iss_v = 1'b1; iss_rd = 5'd0;
    ra = {5'd0, 5'd0};
    tick();
    idle();
    #1;
    checks++; if (rd !== 64'h0) begin errors++; $display("FAIL x0_data got=%h exp=0", rd); end
    checks++; if (rbusy !== 2'b00) begin errors++; $display("FAIL x0_busy got=%b exp=00", rbusy); end
    checks++; if (nbusy !== 6'd0) begin errors++; $display("FAIL x0_nbusy got=%0d exp=0", nbusy); end
  endtask

  task automatic test_scoreboard();
    iss_v = 1'b1; iss_rd = 5'd4;
    ra = {5'd7, 5'd4};
    tick();
    idle();
    #1;
    checks++; if (rbusy !== 2'b01) begin errors++; $display("FAIL sb_issue_rbusy got=%b exp=01", rbusy); end
    checks++; if (nbusy !== 6'd1) begin errors++; $display("FAIL sb_issue_nbusy got=%0d exp=1", nbusy); end
    // writeback and re-issue of x4 together: new producer keeps it busy
    we1 = 1'b1; wa1 = 5'd4; wd1 = 32'h0000_0044;
    iss_v = 1'b1; iss_rd = 5'd4;
    #1;
    checks++; if (rbusy[0] !== 1'b1) begin errors++; $display("FAIL sb_wb_iss_comb got=%b exp=1", rbusy[0]); end
    tick();
    idle();
    #1;
    checks++; if (rbusy[0] !== 1'b1) begin errors++; $display("FAIL sb_wb_iss_rbusy got=%b exp=1", rbusy[0]); end
    checks++; if (nbusy !== 6'd1) begin errors++; $display("FAIL sb_wb_iss_nbusy got=%0d exp=1", nbusy); end
    checks++; if (rd[31:0] !== 32'h0000_0044) begin errors++; $display("FAIL sb_wb_data got=%h exp=00000044", rd[31:0]); end
    we1 = 1'b1; wa1 = 5'd4; wd1 = 32'h0000_0045;
    tick();
    idle();
    #1;
    checks++; if (nbusy !== 6'd0) begin errors++; $display("FAIL sb_wb_nbusy got=%0d exp=0", nbusy); end
    checks++; if (rbusy[0] !== 1'b0) begin errors++; $display("FAIL sb_wb_rbusy got=%b exp=0", rbusy[0]); end
  endtask

  task automatic test_flush();
    for (int r = 1; r <= 3; r++) begin
      iss_v = 1'b1; iss_rd = 5'(r);
      tick();
    end
    idle();
    #1;
    checks++; if (nbusy !== 6'd3) begin errors++; $display("FAIL flush_pre_nbusy got=%0d exp=3", nbusy); end
    flush = 1'b1; iss_v = 1'b1; iss_rd = 5'd9;
    tick();
    idle();
    ra = {5'd1, 5'd9};
    #1;
    checks++; if (nbusy !== 6'd0) begin errors++; $display("FAIL flush_nbusy got=%0d exp=0", nbusy); end
    checks++; if (rbusy !== 2'b00) begin errors++; $display("FAIL flush_rbusy got=%b exp=00", rbusy); end
  endtask

  task automatic test_back_to_back();
    we0 = 1'b1; wa0 = 5'd10; wd0 = 32'hA000_0001;
    we1 = 1'b1; wa1 = 5'd11; wd1 = 32'hB000_0001;
    iss_v = 1'b1; iss_rd = 5'd12;
    tick();
    idle();
    we0 = 1'b1; wa0 = 5'd11; wd0 = 32'hA000_0002;
    ra = {5'd10, 5'd11};
    #1;
    checks++; if (rd[63:32] !== 32'hA000_0001) begin errors++; $display("FAIL b2b_x10 got=%h exp=a0000001", rd[63:32]); end
`ifdef RF_BYPASS_EN
    checks++; if (rd[31:0] !== 32'hA000_0002) begin errors++; $display("FAIL b2b_x11_fwd got=%h exp=a0000002", rd[31:0]); end
`else
    checks++; if (rd[31:0] !== 32'hB000_0001) begin errors++; $display("FAIL b2b_x11_old got=%h exp=b0000001", rd[31:0]); end
`endif
    tick();
    idle();
    #1;
    checks++; if (rd[31:0] !== 32'hA000_0002) begin errors++; $display("FAIL b2b_x11_new got=%h exp=a0000002", rd[31:0]); end
    checks++; if (nbusy !== 6'd1) begin errors++; $display("FAIL b2b_nbusy got=%0d exp=1", nbusy); end
  endtask

  task automatic test_bypass();
    logic [31:0] exp_pre;
    we0 = 1'b1; wa0 = 5'd6; wd0 = 32'hCAFE_0006;
    ra = {5'd6, 5'd12};
`ifdef RF_BYPASS_EN
    exp_pre = 32'hCAFE_0006;
`else
    exp_pre = 32'h0;
`endif
    #1;
    checks++; if (rd[63:32] !== exp_pre) begin errors++; $display("FAIL bypass_comb got=%h exp=%h", rd[63:32], exp_pre); end
    checks++; if (rbusy[0] !== 1'b1) begin errors++; $display("FAIL bypass_x12_busy got=%b exp=1", rbusy[0]); end
    tick();
    idle();
    #1;
    checks++; if (rd[63:32] !== 32'hCAFE_0006) begin errors++; $display("FAIL bypass_after got=%h exp=cafe0006", rd[63:32]); end
  endtask

  task automatic test_async_reset();
    we0 = 1'b1; wa0 = 5'd5; wd0 = 32'h0000_0123;
    iss_v = 1'b1; iss_rd = 5'd13;
    ra = {5'd7, 5'd6};
    #2;
    rstn = 1'b0;
    #1;
    checks++; if (rd !== 64'h0) begin errors++; $display("FAIL async_rd got=%h exp=0", rd); end
    checks++; if (nbusy !== 6'd0) begin errors++; $display("FAIL async_nbusy got=%0d exp=0", nbusy); end
    tick();
    idle();
    rstn = 1'b1;
    tick();
    ra = {5'd13, 5'd5};
    #1;
    checks++; if (rd[31:0] !== 32'h0) begin errors++; $display("FAIL async_discard got=%h exp=0", rd[31:0]); end
    checks++; if (rbusy !== 2'b00) begin errors++; $display("FAIL async_rbusy got=%b exp=00", rbusy); end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_conflict();
    test_x0();
    test_scoreboard();
    test_flush();
    test_back_to_back();
    test_bypass();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
